block_checker: RTL and testbench
================================

# block_checker

Streaming keyword-balance checker: consumes one ASCII character per clock and reports whether the `begin`/`end` words seen so far are properly matched. Words are space-delimited and matched case-insensitively. It sits behind a character source (UART/text feed) and drives a single status flag.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `in`  input  8  ASCII character sampled on each rising `clk` edge.
- `result`  output  1  1 when every `begin` so far is closed by an `end` and no unmatched `end` has been confirmed. Otherwise 0.

## Operation
- Separator is space only (0x20). A word is a maximal run of non-space characters. Multiple, leading or trailing spaces are legal.
- Letters compare case-insensitively: `in | 8'h20` against lowercase ASCII.
- Word-tracking FSM states:
  - IDLE: between words; the reset state.
  - B1..B5: prefix `b`, `be`, `beg`, `begi`, `begin`.
  - E1..E3: prefix `e`, `en`, `end`.
  - OTHER: non-keyword word.
- Transitions:
  - Any state on space goes to IDLE.
  - IDLE on b goes to B1, on e goes to E1, on other non-space goes to OTHER.
  - In Bk/Ek, the correct next letter advances to the next prefix state. Any other non-space goes to OTHER.
  - B5 or E3 on any non-space goes to OTHER.
  - OTHER stays in OTHER until a space.
- Depth counter: signed, 32 bits, reset value 0. Overflow is out of scope.
- Tentative counting:
  - Entering B5 (the `n` of begin): depth += 1.
  - Leaving B5 on a non-space (e.g. `beginx`): depth -= 1, reverting the count.
  - Entering E3 (the `d` of end): depth -= 1.
  - Leaving E3 on a non-space (e.g. `endc`): depth += 1, reverting the count.
- Confirmation: a space received in E3 while depth < 0 sets the sticky flag `broken`. Only reset clears `broken`.
- A space received in B5, or in E3 with depth >= 0, changes nothing beyond the return to IDLE.
- `result = (depth == 0) && !broken`. It is combinational from registered state only, not from `in`.
- Non-letter, non-space characters (digits, punctuation, NUL) are ordinary word characters.

## Timing
- All state updates on rising `clk`. `result` reflects all characters sampled up to and including the most recent edge: 1-cycle latency from `in` to `result`.
- Reset (async, any time, including mid-word) forces IDLE, depth = 0 and `broken` = 0, so `result` = 1 immediately and for as long as reset is held.
- A keyword's effect on `result` appears in the cycle after its last letter. The revert appears in the cycle after the next non-space character.
- A tentative negative depth drives `result` = 0 but is not sticky until the following space. An `endX` before that space restores the prior value.
- Once `broken` is set, `result` stays 0 regardless of later input, until reset.

## Test plan
- Basic balance:
  - Stimulus: reset, then `a`, ` `, `BEGiN`, ` `, `EnD`.
  - Required `result` sequence: 1 after reset, 1 through ` `, 0 after `N`, 1 after `D`.
- Revert on extended word:
  - Stimulus: continue the basic-balance stream with `C`, ` `, `end`, ` `.
  - Required: `result` goes 0 after `C` (depth 1), then 1 after `d` (depth 0), and stays 1 after the space.
- Sticky break:
  - Stimulus: continue with `end`, ` `, `BeGIn`.
  - Required: `result` = 0 after `d` (depth -1). After the space, `broken` = 1. `result` stays 0 through `BeGIn`, even though depth returns to 0.
- Non-sticky negative:
  - Stimulus: reset, `end`, `s`, ` `.
  - Required: `result` 1 → 0 after `d` → 1 after `s` → 1 after the space; `broken` = 0.
- Case and near-miss:
  - Stimulus: reset, `BEGINS`, ` `, `beg`, ` `, `bEgIn`, ` `, `eNd`, ` `.
  - Required: 0 only transiently after `N`. After `beg` the result is 1. After `n` it is 0, and after `d` it is 1.
- Async reset mid-operation:
  - Stimulus: `begin`, `begin` (depth 2), then assert `reset` between clock edges.
  - Required: `result` = 1 immediately with no clock edge. The next `end`, ` ` makes `result` 0 and sets `broken`.

Source files
------------

// File: rtl/block_checker.sv
// Streaming begin/end balance checker: one ASCII character per clock, space-delimited
// words matched case-insensitively, with a single registered-state status flag.
module block_checker (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    output logic       result
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        B1    = 4'd1,
        B2    = 4'd2,
        B3    = 4'd3,
        B4    = 4'd4,
        B5    = 4'd5,
        E1    = 4'd6,
        E2    = 4'd7,
        E3    = 4'd8,
        OTHER = 4'd9
    } state_e;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6e;
    localparam logic [7:0] CH_D     = 8'h64;

    state_e             state_q, state_d;
    logic signed [31:0] depth_q, depth_d;
    logic               broken_q, broken_d;
    logic               is_space;
    logic [7:0]         lc;

    // Space must be detected on the raw byte: NUL | 0x20 also folds to 0x20.
    assign is_space = (in == CH_SPACE);
    assign lc       = in | 8'h20;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            depth_q  <= 32'sd0;
            broken_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            broken_q <= broken_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (is_space) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lc == CH_B)      state_d = B1;
                    else if (lc == CH_E) state_d = E1;
                    else                 state_d = OTHER;
                end
                B1:      state_d = (lc == CH_E) ? B2 : OTHER;
                B2:      state_d = (lc == CH_G) ? B3 : OTHER;
                B3:      state_d = (lc == CH_I) ? B4 : OTHER;
                B4:      state_d = (lc == CH_N) ? B5 : OTHER;
                E1:      state_d = (lc == CH_N) ? E2 : OTHER;
                E2:      state_d = (lc == CH_D) ? E3 : OTHER;
                default: state_d = OTHER;
            endcase
        end
    end

    // Keywords count as soon as their last letter arrives; a further letter reverts it.
    always_comb begin
        depth_d  = depth_q;
        broken_d = broken_q;
        if (is_space) begin
            if (state_q == E3 && depth_q < 32'sd0) broken_d = 1'b1;
        end else if (state_d == B5) begin
            depth_d = depth_q + 32'sd1;
        end else if (state_d == E3) begin
            depth_d = depth_q - 32'sd1;
        end else if (state_q == B5) begin
            depth_d = depth_q - 32'sd1;
        end else if (state_q == E3) begin
            depth_d = depth_q + 32'sd1;
        end
    end

    always_comb begin
        result = (depth_q == 32'sd0) && !broken_q;
    end

endmodule

// File: tb/tb_block_checker.sv
// Bench for block_checker: word-level reference model feeding an expected-result
// queue, drained by an independent monitor one step after each rising edge.
module tb_block_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_c;
    logic       result;

    int checks = 0;
    int errors = 0;

    logic  exp_q[$];
    string name_q[$];

    // Reference model: committed depth of finished words, plus the current word.
    int         m_depth;
    bit         m_broken;
    logic [7:0] m_word[$];

    always #5 clk = ~clk;

    block_checker dut (
        .clk   (clk),
        .reset (reset),
        .in    (in_c),
        .result(result)
    );

    function automatic int word_value();
        logic [39:0] kw_begin;
        logic [23:0] kw_end;
        bit          same;
        kw_begin = "begin";
        kw_end   = "end";
        if (m_word.size() == 5) begin
            same = 1'b1;
            for (int i = 0; i < 5; i++)
                if (m_word[i] != kw_begin[39-8*i -: 8]) same = 1'b0;
            if (same) return 1;
        end
        if (m_word.size() == 3) begin
            same = 1'b1;
            for (int i = 0; i < 3; i++)
                if (m_word[i] != kw_end[23-8*i -: 8]) same = 1'b0;
            if (same) return -1;
        end
        return 0;
    endfunction

    task automatic check(input logic act, input logic exp, input string name);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: result=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] c, input string name);
        int k;
        @(negedge clk);
        in_c = c;
        if (c == 8'h20) begin
            k = word_value();
            if (k == -1 && m_depth - 1 < 0) m_broken = 1'b1;
            m_depth = m_depth + k;
            m_word.delete();
        end else begin
            m_word.push_back(c | 8'h20);
        end
        exp_q.push_back(((m_depth + word_value()) == 0) && !m_broken);
        name_q.push_back(name);
    endtask

    task automatic send_str(input string s, input string name);
        for (int i = 0; i < s.len(); i++) send_char(s[i], name);
    endtask

    task automatic model_clear();
        m_depth  = 0;
        m_broken = 1'b0;
        m_word.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1 check(result, 1'b1, "reset_now");
        repeat (2) @(negedge clk);
        check(result, 1'b1, "reset_hold");
        reset = 1'b0;
        in_c  = 8'h20;
        model_clear();
    endtask

    // Reset asserted between edges; result must rise without any clock edge.
    task automatic async_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check(result, 1'b1, "async_reset");
        @(negedge clk);
        reset = 1'b0;
        in_c  = 8'h20;
        model_clear();
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(result, e, n);
        end
    end

    initial begin
        string toks[11];
        string t;
        logic [7:0] c;
        toks = '{"begin", "end", "beg", "endx", "beginx", "en", "b", "e", "x1", "BEGIN", "End"};
        reset = 1'b1;
        in_c  = 8'h20;
        model_clear();
        #12;
        do_reset();

        send_str("a BEGiN EnD", "basic");
        send_str("C end ", "revert");
        send_str("end BeGIn", "sticky");
        send_str("  end begin ", "sticky_hold");

        do_reset();
        send_str("ends ", "nonsticky");
        send_str("begin end ", "nonsticky_after");

        do_reset();
        send_str("BEGINS beg bEgIn eNd ", "case_nearmiss");

        do_reset();
        send_str("begin begin", "async_pre");
        async_reset();
        send_str("end ", "after_async");
        send_str("begin", "after_async_sticky");

        do_reset();
        for (int n = 0; n < 500; n++) begin
            if (n % 60 == 59) do_reset();
            if ($urandom_range(0, 9) == 0) begin
                c = 8'($urandom_range(0, 126));
                if (c == 8'h20) c = 8'h00;
                send_char(c, "rand_byte");
            end else begin
                t = toks[$urandom_range(0, 10)];
                for (int i = 0; i < t.len(); i++) begin
                    c = t[i];
                    if (((c | 8'h20) >= 8'h61) && ((c | 8'h20) <= 8'h7a) && $urandom_range(0, 1) == 1)
                        c = c ^ 8'h20;
                    send_char(c, "rand_word");
                end
            end
            repeat ($urandom_range(1, 2)) send_char(8'h20, "rand_space");
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
